instr_mem_responder: RTL and testbench

- Instruction-memory responder for the calculator CPU, which acts as the fetch initiator.
- Holds a 35-bit instruction program written sequentially through a load port.
- After loading, answers CPU fetch requests (byte address from the PC) with one instruction per accepted request.
- Response latency is 1 cycle; a single output register provides backpressure.

---
 rtl/instr_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_instr_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
//
// Instruction memory for the calculator CPU. A program of 35-bit instruction
// words is written sequentially through the load port. After load_done, the
// block answers CPU fetch requests with one instruction per accepted request.
// Response latency is one cycle. A single response register provides
// backpressure.
//
// Instruction word layout:
//   [34] accum_wren, [33] subtract, [32] novel-op mux select,
//   [31:16] immA, [15:0] immB
//
// Optional feature macro: INSTR_MEM_RELOAD_EN
//   Defined   : adds input 'reload'. From RUN with no response pending, it
//               returns the block to LOAD with an empty program.
//   Undefined : RUN is terminal until reset_n is asserted.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   load_valid       in   load word present
//   load_data        in   35-bit instruction word to store
//   load_ready       out  a load word can be accepted (LOAD and not full)
//   load_done        in   single-cycle pulse that ends the load phase
//   fetch_req_valid  in   CPU fetch request
//   fetch_req_ready  out  request accepted when valid & ready
//   fetch_addr       in   32-bit byte address from the PC
//   fetch_resp_valid out  response present
//   fetch_resp_ready in   CPU consumes the response
//   fetch_resp_instr out  fetched instruction (0 on error)
//   fetch_resp_err   out  misaligned or out-of-program fetch
//   prog_len         out  number of words loaded
//   run_mode         out  0 = LOAD, 1 = RUN
//   reload           in   (INSTR_MEM_RELOAD_EN only) return to LOAD
// ---------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [34:0]      load_data,
    output logic             load_ready,
    input  logic             load_done,
    input  logic             fetch_req_valid,
    output logic             fetch_req_ready,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_resp_valid,
    input  logic             fetch_resp_ready,
    output logic [34:0]      fetch_resp_instr,
    output logic             fetch_resp_err,
    output logic [PTR_W-1:0] prog_len,
    output logic             run_mode
`ifdef INSTR_MEM_RELOAD_EN
    ,
    input  logic             reload
`endif
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_resp_valid;
    logic [34:0]      r_resp_instr;
    logic             r_resp_err;

    // Program storage. It is deliberately not reset: contents survive
    // reset_n, but prog_len returns to 0, so every fetch errors until the
    // program is reloaded.
    logic [34:0]      r_mem [DEPTH];

    logic             w_load_ready;
    logic             w_load_fire;
    logic             w_reload_go;
    logic             w_req_ready;
    logic             w_accept;
    logic [29:0]      w_index;
    logic [29:0]      w_len_ext;
    logic             w_fetch_err;
    logic [34:0]      w_mem_word;
    logic [34:0]      w_fetch_instr;

    // The load pointer never passes DEPTH. Once the memory is full, further
    // load words are refused rather than wrapping over word 0.
    assign w_load_ready = (r_state == S_LOAD) && (r_ptr < DEPTH_P);
    assign w_load_fire  = w_load_ready && load_valid;

`ifdef INSTR_MEM_RELOAD_EN
    // Reload is honoured only when no response is pending. The requester
    // must hold reload until the response drains.
    assign w_reload_go = (r_state == S_RUN) && !r_resp_valid && reload;
`else
    assign w_reload_go = 1'b0;
`endif

    // A request is refused in the cycle a reload is honoured, so no fetch
    // result is produced against the program being discarded.
    assign w_req_ready = (r_state == S_RUN)
                       && (!r_resp_valid || fetch_resp_ready)
                       && !w_reload_go;
    assign w_accept    = fetch_req_valid && w_req_ready;

    // Compare the full 30-bit word index so high address bits cannot alias
    // onto a valid program word.
    assign w_index       = fetch_addr[31:2];
    assign w_len_ext     = {{(30-PTR_W){1'b0}}, r_ptr};
    assign w_fetch_err   = (fetch_addr[1:0] != 2'b00) || (w_index >= w_len_ext);
    assign w_mem_word    = r_mem[w_index[IDX_W-1:0]];
    assign w_fetch_instr = w_fetch_err ? 35'd0 : w_mem_word;

    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_ptr[IDX_W-1:0]] <= load_data;
        end
    end

    // Control FSM and response register. prog_len is the load pointer itself,
    // because after each write the pointer equals the number of words stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_instr <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // A word arriving alongside load_done is still written.
                    if (w_load_fire) begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                    if (load_done) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_reload_go) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase

            // A new accept takes priority over a drain, so back-to-back
            // fetches keep valid high and update the data each cycle.
            if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_resp_instr <= w_fetch_instr;
                r_resp_err   <= w_fetch_err;
            end else if (fetch_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign load_ready       = w_load_ready;
    assign fetch_req_ready  = w_req_ready;
    assign fetch_resp_valid = r_resp_valid;
    assign fetch_resp_instr = r_resp_instr;
    assign fetch_resp_err   = r_resp_err;
    assign prog_len         = r_ptr;
    assign run_mode         = (r_state == S_RUN);

endmodule

// File: tb/tb_instr_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_responder
//
// Directed bench for instr_mem_responder. It covers the reset state, loading
// the program, back-to-back fetches, a table of fetch vectors (good words,
// misaligned addresses and out-of-program addresses), backpressure, reset
// during a response, overflow of the load port and, when
// INSTR_MEM_RELOAD_EN is defined, reload.
// ---------------------------------------------------------------------------
module tb_instr_mem_responder;

    localparam int DEPTH = 64;
    localparam int PTR_W = 7;

    logic             clk;
    logic             reset_n;
    logic             load_valid;
    logic [34:0]      load_data;
    logic             load_ready;
    logic             load_done;
    logic             fetch_req_valid;
    logic             fetch_req_ready;
    logic [31:0]      fetch_addr;
    logic             fetch_resp_valid;
    logic             fetch_resp_ready;
    logic [34:0]      fetch_resp_instr;
    logic             fetch_resp_err;
    logic [PTR_W-1:0] prog_len;
    logic             run_mode;
`ifdef INSTR_MEM_RELOAD_EN
    logic             reload;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [34:0] W0 = 35'h4_0001_0002;
    localparam logic [34:0] W1 = 35'h6_0003_0004;
    localparam logic [34:0] W2 = 35'h1_0005_0006;

    typedef struct {
        logic [31:0] addr;
        logic [34:0] instr;
        logic        err;
    } fvec_t;

    fvec_t vecs [9];

    instr_mem_responder #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_ready       (load_ready),
        .load_done        (load_done),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_addr       (fetch_addr),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_ready (fetch_resp_ready),
        .fetch_resp_instr (fetch_resp_instr),
        .fetch_resp_err   (fetch_resp_err),
        .prog_len         (prog_len),
        .run_mode         (run_mode)
`ifdef INSTR_MEM_RELOAD_EN
        ,
        .reload           (reload)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [34:0] w, input logic done);
        load_valid = 1'b1;
        load_data  = w;
        load_done  = done;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #7;
        reset_n = 1'b1;
        tick();
    endtask

    // Single fetch with the response consumed immediately.
    task automatic fetch_one(input string name, input logic [31:0] a,
                             input logic [34:0] ei, input logic ee);
        fetch_req_valid  = 1'b1;
        fetch_addr       = a;
        fetch_resp_ready = 1'b1;
        tick();
        fetch_req_valid  = 1'b0;
        chk({name, "_valid"}, fetch_resp_valid, 1);
        chk({name, "_instr"}, fetch_resp_instr, ei);
        chk({name, "_err"},   fetch_resp_err,   ee);
        tick();
        chk({name, "_drain"}, fetch_resp_valid, 0);
    endtask

    function automatic logic [34:0] ovw(input int i);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'hA000 + 16'(i);
        b = 16'h5000 + 16'(i);
        return {3'b101, a, b};
    endfunction

    initial begin
        reset_n          = 1'b0;
        load_valid       = 1'b0;
        load_data        = '0;
        load_done        = 1'b0;
        fetch_req_valid  = 1'b0;
        fetch_addr       = '0;
        fetch_resp_ready = 1'b0;
`ifdef INSTR_MEM_RELOAD_EN
        reload           = 1'b0;
`endif

        vecs[0] = '{32'h0000_0000, W0,    1'b0};
        vecs[1] = '{32'h0000_0004, W1,    1'b0};
        vecs[2] = '{32'h0000_0008, W2,    1'b0};
        vecs[3] = '{32'h0000_000C, 35'd0, 1'b1};
        vecs[4] = '{32'h0000_0006, 35'd0, 1'b1};
        vecs[5] = '{32'h0000_0001, 35'd0, 1'b1};
        vecs[6] = '{32'h0000_0100, 35'd0, 1'b1};
        vecs[7] = '{32'h4000_0000, 35'd0, 1'b1};
        vecs[8] = '{32'h8000_0008, 35'd0, 1'b1};

        // Reset state
        #12;
        chk("rst_run_mode",   run_mode,         0);
        chk("rst_prog_len",   prog_len,         0);
        chk("rst_resp_valid", fetch_resp_valid, 0);
        chk("rst_resp_instr", fetch_resp_instr, 0);
        chk("rst_resp_err",   fetch_resp_err,   0);
        chk("rst_load_ready", load_ready,       1);
        chk("rst_req_ready",  fetch_req_ready,  0);
        reset_n = 1'b1;
        tick();

        // Load three words; the last word arrives together with load_done.
        fetch_req_valid = 1'b1;
        #1;
        chk("load_req_ready", fetch_req_ready, 0);
        fetch_req_valid = 1'b0;
        load_word(W0, 1'b0);
        chk("load_len1", prog_len, 1);
        load_word(W1, 1'b0);
        load_word(W2, 1'b1);
        chk("load_len3",   prog_len,   3);
        chk("load_run",    run_mode,   1);
        chk("run_ldready", load_ready, 0);

        // Back-to-back fetches of addresses 0, 4 and 8.
        fetch_req_valid  = 1'b1;
        fetch_addr       = 32'h0;
        fetch_resp_ready = 1'b1;
        #1;
        chk("b2b_req_ready", fetch_req_ready, 1);
        chk("b2b_lat",       fetch_resp_valid, 0);
        tick();
        chk("b2b0_valid", fetch_resp_valid, 1);
        chk("b2b0_instr", fetch_resp_instr, W0);
        chk("b2b0_err",   fetch_resp_err,   0);
        fetch_addr = 32'h4;
        tick();
        chk("b2b1_valid", fetch_resp_valid, 1);
        chk("b2b1_instr", fetch_resp_instr, W1);
        chk("b2b1_err",   fetch_resp_err,   0);
        fetch_addr = 32'h8;
        tick();
        chk("b2b2_valid", fetch_resp_valid, 1);
        chk("b2b2_instr", fetch_resp_instr, W2);
        chk("b2b2_err",   fetch_resp_err,   0);
        fetch_req_valid = 1'b0;
        tick();
        chk("b2b_drain", fetch_resp_valid, 0);

        // Table of fetch vectors.
        for (int i = 0; i < 9; i++) begin
            fetch_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err);
        end

        // Backpressure: the response for address 4 is held for three cycles.
        fetch_req_valid  = 1'b1;
        fetch_addr       = 32'h4;
        fetch_resp_ready = 1'b0;
        tick();
        fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_valid", i), fetch_resp_valid, 1);
            chk($sformatf("bp%0d_instr", i), fetch_resp_instr, W1);
            chk($sformatf("bp%0d_err", i),   fetch_resp_err,   0);
            chk($sformatf("bp%0d_ready", i), fetch_req_ready,  0);
            tick();
        end
        fetch_resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", fetch_req_ready, 1);
        tick();
        chk("bp_next_valid", fetch_resp_valid, 1);
        chk("bp_next_instr", fetch_resp_instr, W2);
        fetch_req_valid = 1'b0;
        tick();
        chk("bp_drain", fetch_resp_valid, 0);

        // Reset asserted while a response is pending.
        fetch_req_valid  = 1'b1;
        fetch_addr       = 32'h0;
        fetch_resp_ready = 1'b0;
        tick();
        fetch_req_valid = 1'b0;
        chk("mid_valid_pre", fetch_resp_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_valid_async", fetch_resp_valid, 0);
        chk("mid_instr_async", fetch_resp_instr, 0);
        chk("mid_run_async",   run_mode,         0);
        #3;
        reset_n = 1'b1;
        fetch_resp_ready = 1'b1;
        tick();
        chk("mid_run_mode",   run_mode,         0);
        chk("mid_prog_len",   prog_len,         0);
        chk("mid_valid_post", fetch_resp_valid, 0);
        pulse_done();
        chk("empty_run",  run_mode, 1);
        chk("empty_len",  prog_len, 0);
        fetch_one("empty_fetch0", 32'h0, 35'd0, 1'b1);

        // Overflow: DEPTH+2 load words, only DEPTH of them stored.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            load_data  = (i >= DEPTH) ? 35'h7_FFFF_FFFF : ovw(i);
            #1;
            chk($sformatf("ov_ready%0d", i), load_ready, (i < DEPTH) ? 1 : 0);
            tick();
        end
        load_valid = 1'b0;
        chk("ov_len",      prog_len,   DEPTH);
        chk("ov_ready_end", load_ready, 0);
        pulse_done();
        fetch_one("ov_fetch0",  32'h0,          ovw(0),  1'b0);
        fetch_one("ov_fetch63", 32'(4 * 63),    ovw(63), 1'b0);
        fetch_one("ov_fetch64", 32'(4 * DEPTH), 35'd0,   1'b1);

`ifdef INSTR_MEM_RELOAD_EN
        // Reload is ignored while a response is pending.
        fetch_req_valid  = 1'b1;
        fetch_addr       = 32'h4;
        fetch_resp_ready = 1'b0;
        tick();
        fetch_req_valid = 1'b0;
        reload          = 1'b1;
        tick();
        chk("rl_ignored_run",   run_mode,         1);
        chk("rl_ignored_valid", fetch_resp_valid, 1);
        chk("rl_ignored_instr", fetch_resp_instr, ovw(1));
        fetch_resp_ready = 1'b1;
        tick();
        chk("rl_drained_valid", fetch_resp_valid, 0);
        chk("rl_drained_run",   run_mode,         1);
        // Honoured reload; a request in the same cycle is refused.
        fetch_req_valid = 1'b1;
        fetch_addr      = 32'h0;
        #1;
        chk("rl_req_ready", fetch_req_ready, 0);
        tick();
        reload          = 1'b0;
        fetch_req_valid = 1'b0;
        chk("rl_run_mode",   run_mode,         0);
        chk("rl_prog_len",   prog_len,         0);
        chk("rl_load_ready", load_ready,       1);
        chk("rl_no_resp",    fetch_resp_valid, 0);
        load_word(W1, 1'b0);
        pulse_done();
        chk("rl_len1", prog_len, 1);
        fetch_one("rl_fetch0", 32'h0, W1,    1'b0);
        fetch_one("rl_fetch4", 32'h4, 35'd0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
